// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command issuer: opcodes, the hold
// opcode, the packed command word and the issuer FSM states.
package calc_pkg;

  localparam int CALC_N = 8;

  localparam logic [2:0] OP_RST = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  // OR with uas=1 and zero operands re-saves the core's current result.
  localparam logic [2:0] HOLD_OPE = OP_OR;

  typedef struct packed {
    logic [2:0]        ope;
    logic              uas;
    logic [CALC_N-1:0] in1;
    logic [CALC_N-1:0] in2;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Show-ahead command FIFO; wrapping pointers address storage, an occupancy
// counter provides full/empty.
module calc_cmd_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  cmd_t          mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; empty/full gate every read, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/calc_cmd_issuer.sv
// Feeds queued commands to the calculator core one cycle at a time and returns
// each result; drives a hold op otherwise so the core's saved result survives.
module calc_cmd_issuer
  import calc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int N     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_ope,
  input  logic         cmd_uas,
  input  logic [N-1:0] cmd_in1,
  input  logic [N-1:0] cmd_in2,
  output logic [2:0]   alu_ope,
  output logic         alu_uas,
  output logic [N-1:0] alu_in1,
  output logic [N-1:0] alu_in2,
  input  logic [N-1:0] alu_out,
  input  logic         alu_err,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_err,
  output logic [7:0]   err_cnt
);

  state_t state;
  state_t next_state;
  cmd_t   cmd_in;
  cmd_t   head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   clr_core;

  assign cmd_in    = '{ope: cmd_ope, uas: cmd_uas, in1: cmd_in1, in2: cmd_in2};
  assign cmd_ready = rst_n && !fifo_full;

  calc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .wdata (cmd_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // clr_core keeps the RST drive on the core until the first edge out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_core <= 1'b1;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      clr_core <= 1'b0;
      if (state == ST_ISSUE) begin
        rsp_data <= alu_out;
        rsp_err  <= alu_err;
        if (alu_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    next_state = state;
    pop        = 1'b0;
    rsp_valid  = 1'b0;
    alu_ope    = HOLD_OPE;
    alu_uas    = 1'b1;
    alu_in1    = '0;
    alu_in2    = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        alu_ope    = head.ope;
        alu_uas    = head.uas;
        alu_in1    = head.in1;
        alu_in2    = head.in2;
        pop        = 1'b1;
        next_state = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = fifo_empty ? ST_IDLE : ST_ISSUE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (clr_core) begin
      alu_ope = OP_RST;
      alu_uas = 1'b0;
      alu_in1 = '0;
      alu_in2 = '0;
    end
  end

endmodule

// File: doc/calc_cmd_issuer.md
# calc_cmd_issuer

Command-side driver for the 8-bit calculator core (`controlUnit`). It accepts queued calculator commands over a valid/ready interface and presents each one to the core for exactly one clock. It returns each captured result and error flag over a second valid/ready interface. Between commands it drives a hold operation so the core's saved-result register survives idle and back-pressure cycles, which makes `uas` chaining reliable.

## Interface
- `DEPTH`, default 4: command FIFO entries, power of two, at least 2.
- `N`, default 8: operand and result width. Fixed at 8 for the current core.

Ports:
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: reset, synchronous, active-low.
- `cmd_valid` input, 1: command offered.
- `cmd_ready` output, 1: FIFO not full; equals `!full`, combinational.
- `cmd_ope` input, 3: operation code.
- `cmd_uas` input, 1: use saved result as the second operand.
- `cmd_in1` input, N: operand 1.
- `cmd_in2` input, N: operand 2.
- `alu_ope` output, 3: to core `ope`.
- `alu_uas` output, 1: to core `uas`.
- `alu_in1` output, N: to core `in1`.
- `alu_in2` output, N: to core `in2`.
- `alu_out` input, N: from core `out`, combinational in the issue cycle.
- `alu_err` input, 1: from core `err`.
- `rsp_valid` output, 1: result held.
- `rsp_ready` input, 1: consumer accepts the result.
- `rsp_data` output, N: captured result.
- `rsp_err` output, 1: captured error.
- `err_cnt` output, 8: count of issued commands with `alu_err`=1; saturates at 255.

## Operation
- Opcodes: 000 RST, 001 ADD, 010 SUB, 011 MUL, 100 AND, 101 OR, 110 NOT, 111 XOR.
- Hold drive is `alu_ope`=101, `alu_uas`=1, `alu_in1`=0, `alu_in2`=0. This gives core `ans` = `res`|0 = `res`, so the saved result is preserved.
- Reset drive is `alu_ope`=000 with all other ALU outputs 0. It clears the core's saved result.
- FSM states:
  - IDLE: drive hold. If the FIFO is non-empty, go to ISSUE.
  - ISSUE: drive the FIFO head onto the `alu_*` ports for exactly one cycle. At the closing edge:
    - capture `alu_out` into `rsp_data` and `alu_err` into `rsp_err`;
    - pop the FIFO;
    - increment `err_cnt` if `alu_err`=1 and `err_cnt` < 255;
    - go to RESP.
  - RESP: drive hold with `rsp_valid`=1. On `rsp_ready`=1: go to ISSUE if the FIFO is non-empty, otherwise go to IDLE.
- Only one command is outstanding at a time. A command is never issued for more than one cycle.
- A push and a pop in the same cycle are both honoured. `cmd_ready` does not anticipate a same-cycle pop.
- A RST command is issued like any other command and returns `rsp_data`=0, `rsp_err`=0.

## Timing
- Reset values while `rst_n`=0:
  - FIFO empty, state IDLE;
  - `cmd_ready`=0;
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `err_cnt`=0;
  - ALU ports carry the reset drive.
- The first edge with `rst_n`=1 moves ALU ports to the hold drive.
- Latency: a command accepted into an empty FIFO while IDLE at edge E0 is in ISSUE during E1–E2. `rsp_valid` rises after E2, giving 2 cycles from acceptance to response.
- Back-to-back throughput: with `rsp_ready` tied high, one response every 2 cycles (ISSUE, RESP, ISSUE, ...).
- `rsp_data` and `rsp_err` stay stable while `rsp_valid`=1 and `rsp_ready`=0.
- Full FIFO: `cmd_ready`=0 and offered commands are not consumed.
- Reset mid-operation: any state is abandoned. The queued command and the pending response are discarded, and the core's saved result is cleared.

## Structure
- Shared package `calc_pkg`:
  - opcode constants `OP_RST` through `OP_XOR`;
  - `HOLD_OPE`=3'b101;
  - a packed command typedef `{ope, uas, in1, in2}`;
  - the FSM state enum.
- Sub-module `calc_cmd_fifo`: synchronous FIFO, DEPTH × command width, with pointer wrap on log2(DEPTH) bits plus an occupancy counter for full/empty.

## Test plan
- Chained add: reset, then ADD uas=0 3,4. Expect `rsp_data`=7, `rsp_err`=0, and `rsp_valid` exactly 2 cycles after acceptance.
- Hold across idle: ADD 2,2 returns 4. Then hold `rsp_ready`=0 for 5 cycles, then leave the block idle for 3 cycles. Then ADD uas=1 in1=7. Expect 11.
- Errors: ADD 255,1 expects data 0, err 1. Then SUB 1,255 expects data 2, err 1. Then `err_cnt`=2. MUL 16,16 expects data 0, err 1, and `err_cnt`=3.
- Back-pressure: hold `rsp_ready`=0 and offer 7 commands back-to-back.
  - 5 are accepted: 1 is issued and 4 are queued. `cmd_ready` is then 0.
  - Then release `rsp_ready`. All 5 responses return in order, one every 2 cycles.
- Reset mid-RESP: with 2 commands queued and `rsp_valid`=1, pulse `rst_n` low for 1 cycle. Expect `rsp_valid`=0 and the FIFO empty. Then ADD uas=1 in1=5 returns 5, because the saved result was cleared.
- RST command: XOR 0x0F,0xFF returns 0xF0. Then RST returns 0. Then MUL uas=1 in1=9 returns 0.
